// File: rtl/uart_pkg.sv
// Types and defaults shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and baud tick in, received byte and status out.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);

  logic                 b_16tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    input  b_16tick,
    input  rx,
    output rx_data,
    output rx_done,
    output rx_busy,
    output frame_err,
    output parity_err
  );

  modport slave (
    output b_16tick,
    output rx,
    input  rx_data,
    input  rx_done,
    input  rx_busy,
    input  frame_err,
    input  parity_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Flop chain bringing the asynchronous rx line into the clk domain; presets to the idle (high) level.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled on b_16tick, LSB first.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | validating start bit at its midpoint
// DATA   | sampling payload bits mid-bit
// PARITY | sampling parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling stop bit, reporting the byte
// BREAK  | stop bit was low; wait for line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_hit;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (bus.rx),
    .rx_s (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (bus.b_16tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == MID_TICK) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        DATA: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
`endif
        STOP: begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            state_d = rx_s ? IDLE : BREAK;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        // A held-low line stays here so it cannot be mistaken for a new start bit.
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stop_hit = bus.b_16tick && (state_q == STOP) && (tick_q == LAST_TICK);
    done_d   = stop_hit;
    data_d   = stop_hit ? shift_q : data_q;
    ferr_d   = stop_hit && !rx_s;
`ifdef UART_RX_PARITY_EN
    perr_d   = stop_hit && (par_q != ^shift_q);
`endif
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.rx_busy   = (state_q != IDLE);
  assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clks, one bit = 16 ticks = 64 clks.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] tcnt = 2'd0;

  int tests_run    = 0;
  int tests_failed = 0;

  int         done_cnt = 0;
  logic [7:0] data_log[$];
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;

`ifdef UART_RX_PARITY_EN
  logic use_par_val = 1'b0;
  logic par_val     = 1'b0;
`endif

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign bus.b_16tick = (tcnt == 2'd0);

  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      done_cnt++;
      data_log.push_back(bus.rx_data);
      last_ferr = bus.frame_err;
      last_perr = bus.parity_err;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    bus.rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = use_par_val ? par_val : ^d;
    wait_clks(BIT_CLKS);
`endif
    bus.rx = stop_bit;
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.rx = 1'b1;
    wait_clks(6);
    tests_run++;
    if (bus.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); end
    rst = 1'b0;
    wait_clks(2);
    tests_run++;
    if (bus.rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
    tests_run++;
    if (bus.rx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.rx_done); end
    tests_run++;
    if (bus.frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); end
    tests_run++;
    if (bus.parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b expected 0", bus.parity_err); end
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_basic();
    int n0;
    n0 = done_cnt;
    send_frame(8'h55, 1'b1);
    wait_clks(8);
    tests_run++;
    if (done_cnt - n0 !== 1) begin tests_failed++; $display("FAIL basic_strobes: got %0d expected 1", done_cnt - n0); end
    tests_run++;
    if (data_log[$] !== 8'h55) begin tests_failed++; $display("FAIL basic_data: got %h expected 55", data_log[$]); end
    tests_run++;
    if (last_ferr !== 1'b0) begin tests_failed++; $display("FAIL basic_ferr: got %b expected 0", last_ferr); end
    tests_run++;
    if (last_perr !== 1'b0) begin tests_failed++; $display("FAIL basic_perr: got %b expected 0", last_perr); end
    tests_run++;
    if (bus.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %b expected 0", bus.rx_busy); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = done_cnt;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_clks(8);
    tests_run++;
    if (done_cnt - n0 !== 2) begin tests_failed++; $display("FAIL b2b_strobes: got %0d expected 2", done_cnt - n0); end
    if (done_cnt - n0 == 2) begin
      tests_run++;
      if (data_log[n0] !== 8'hA3) begin tests_failed++; $display("FAIL b2b_first: got %h expected a3", data_log[n0]); end
      tests_run++;
      if (data_log[n0+1] !== 8'h3C) begin tests_failed++; $display("FAIL b2b_second: got %h expected 3c", data_log[n0+1]); end
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = done_cnt;
    bus.rx = 1'b0;
    wait_clks(6 * 4);
    tests_run++;
    if (bus.rx_busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_high: got %b expected 1", bus.rx_busy); end
    bus.rx = 1'b1;
    wait_clks(BIT_CLKS);
    tests_run++;
    if (bus.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_low: got %b expected 0", bus.rx_busy); end
    tests_run++;
    if (done_cnt - n0 !== 0) begin tests_failed++; $display("FAIL glitch_no_strobe: got %0d expected 0", done_cnt - n0); end
    send_frame(8'h81, 1'b1);
    wait_clks(8);
    tests_run++;
    if (done_cnt - n0 !== 1) begin tests_failed++; $display("FAIL glitch_next_strobes: got %0d expected 1", done_cnt - n0); end
    tests_run++;
    if (data_log[$] !== 8'h81) begin tests_failed++; $display("FAIL glitch_next_data: got %h expected 81", data_log[$]); end
  endtask

  task automatic test_break();
    int n0;
    n0 = done_cnt;
    send_frame(8'h0F, 1'b0);
    wait_clks(40 * 4);
    tests_run++;
    if (done_cnt - n0 !== 1) begin tests_failed++; $display("FAIL break_strobes: got %0d expected 1", done_cnt - n0); end
    tests_run++;
    if (data_log[$] !== 8'h0F) begin tests_failed++; $display("FAIL break_data: got %h expected 0f", data_log[$]); end
    tests_run++;
    if (last_ferr !== 1'b1) begin tests_failed++; $display("FAIL break_ferr: got %b expected 1", last_ferr); end
    tests_run++;
    if (last_perr !== 1'b0) begin tests_failed++; $display("FAIL break_perr: got %b expected 0", last_perr); end
    tests_run++;
    if (bus.rx_busy !== 1'b1) begin tests_failed++; $display("FAIL break_busy_held: got %b expected 1", bus.rx_busy); end
    bus.rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    tests_run++;
    if (done_cnt - n0 !== 1) begin tests_failed++; $display("FAIL break_release_strobes: got %0d expected 1", done_cnt - n0); end
    tests_run++;
    if (bus.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL break_release_busy: got %b expected 0", bus.rx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    n0 = done_cnt;
    bus.rx = 1'b0;
    wait_clks(BIT_CLKS);
    bus.rx = 1'b1;
    wait_clks(3 * BIT_CLKS);
    tests_run++;
    if (bus.rx_busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.rx_busy); end
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    tests_run++;
    if (bus.rx_busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", bus.rx_busy); end
    tests_run++;
    if (bus.rx_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data: got %h expected 00", bus.rx_data); end
    tests_run++;
    if (bus.frame_err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ferr: got %b expected 0", bus.frame_err); end
    wait_clks(7 * BIT_CLKS);
    tests_run++;
    if (done_cnt - n0 !== 0) begin tests_failed++; $display("FAIL rstmid_no_strobe: got %0d expected 0", done_cnt - n0); end
    send_frame(8'h12, 1'b1);
    wait_clks(8);
    tests_run++;
    if (done_cnt - n0 !== 1) begin tests_failed++; $display("FAIL rstmid_next_strobes: got %0d expected 1", done_cnt - n0); end
    tests_run++;
    if (data_log[$] !== 8'h12) begin tests_failed++; $display("FAIL rstmid_next_data: got %h expected 12", data_log[$]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int n0;
    n0 = done_cnt;
    use_par_val = 1'b1;
    par_val     = 1'b0;
    send_frame(8'h07, 1'b1);
    wait_clks(8);
    tests_run++;
    if (last_perr !== 1'b1) begin tests_failed++; $display("FAIL parity_bad: got %b expected 1", last_perr); end
    tests_run++;
    if (data_log[$] !== 8'h07) begin tests_failed++; $display("FAIL parity_bad_data: got %h expected 07", data_log[$]); end
    par_val = 1'b1;
    send_frame(8'h07, 1'b1);
    wait_clks(8);
    tests_run++;
    if (last_perr !== 1'b0) begin tests_failed++; $display("FAIL parity_good: got %b expected 0", last_perr); end
    tests_run++;
    if (done_cnt - n0 !== 2) begin tests_failed++; $display("FAIL parity_strobes: got %0d expected 2", done_cnt - n0); end
    use_par_val = 1'b0;
  endtask
`endif

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
